// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Fetch-stage next-PC generator driving the BTB read port and the
//            fetch request stream; backend redirects override predictions.
//            Optional perf counters enabled by macro FETCH_PC_GEN_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_redirect_valid,
    input  logic [31:0] io_redirect_target,
    output logic [31:0] io_btb_req_pc,
    input  logic        io_btb_hit,
    input  logic [31:0] io_btb_target,
    input  logic        io_btb_jump,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_bits_pc,
    output logic        io_out_bits_pred_taken,
    output logic [31:0] io_out_bits_pred_target
`ifdef FETCH_PC_GEN_PERF_EN
    ,
    output logic [31:0] io_perf_pred_taken_cnt,
    output logic [31:0] io_perf_redirect_cnt
`endif
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        hold_taken_q, hold_taken_d;
    logic [31:0] hold_target_q, hold_target_d;

    logic        w_live_taken;
    logic [31:0] w_live_target;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;
    logic        w_redirect;
    logic        w_fire;
    logic        w_unused_bits;

    assign w_live_taken  = io_btb_hit & io_btb_jump;
    assign w_live_target = {io_btb_target[31:2], 2'b00};
    assign w_redirect_pc = {io_redirect_target[31:2], 2'b00};
    assign w_pc_inc      = pc_q + c_PC_STEP;
    assign w_unused_bits = ^{io_btb_target[1:0], io_redirect_target[1:0]};

    // A redirect only counts once the generator has left BOOT.
    assign w_redirect = io_redirect_valid & (state_q != S_BOOT);

    assign io_out_valid  = (state_q != S_BOOT) & ~w_redirect;
    assign w_fire        = io_out_valid & io_out_ready;
    assign io_btb_req_pc = pc_q;
    assign io_out_bits_pc = pc_q;

    // While stalled the request is served from the captured prediction so a
    // BTB update during backpressure cannot change the bits under the consumer.
    assign io_out_bits_pred_taken  = (state_q == S_HOLD) ? hold_taken_q  : w_live_taken;
    assign io_out_bits_pred_target = (state_q == S_HOLD) ? hold_target_q : w_live_target;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_taken_d  = hold_taken_q;
        hold_target_d = hold_target_q;
        if (w_redirect) begin
            state_d       = S_RUN;
            pc_d          = w_redirect_pc;
            hold_taken_d  = 1'b0;
            hold_target_d = 32'd0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (io_out_ready) begin
                        pc_d = w_live_taken ? w_live_target : w_pc_inc;
                    end else begin
                        hold_taken_d  = w_live_taken;
                        hold_target_d = w_live_target;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (io_out_ready) begin
                        pc_d          = hold_taken_q ? hold_target_q : w_pc_inc;
                        hold_taken_d  = 1'b0;
                        hold_target_d = 32'd0;
                        state_d       = S_RUN;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            hold_taken_q  <= 1'b0;
            hold_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_taken_q  <= hold_taken_d;
            hold_target_q <= hold_target_d;
        end
    end

`ifdef FETCH_PC_GEN_PERF_EN
    logic [31:0] pred_taken_cnt_q, pred_taken_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        pred_taken_cnt_d = pred_taken_cnt_q;
        redirect_cnt_d   = redirect_cnt_q;
        if (w_fire && io_out_bits_pred_taken) begin
            pred_taken_cnt_d = pred_taken_cnt_q + 32'd1;
        end
        if (w_redirect) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pred_taken_cnt_q <= 32'd0;
            redirect_cnt_q   <= 32'd0;
        end else begin
            pred_taken_cnt_q <= pred_taken_cnt_d;
            redirect_cnt_q   <= redirect_cnt_d;
        end
    end

    assign io_perf_pred_taken_cnt = pred_taken_cnt_q;
    assign io_perf_redirect_cnt   = redirect_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Self-checking bench for fetch_pc_gen: directed scenarios plus a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam logic [31:0] c_RV = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_redirect_valid;
    logic [31:0] io_redirect_target;
    logic [31:0] io_btb_req_pc;
    logic        io_btb_hit;
    logic [31:0] io_btb_target;
    logic        io_btb_jump;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_bits_pc;
    logic        io_out_bits_pred_taken;
    logic [31:0] io_out_bits_pred_target;
`ifdef FETCH_PC_GEN_PERF_EN
    logic [31:0] io_perf_pred_taken_cnt;
    logic [31:0] io_perf_redirect_cnt;
`endif

    always #5 clock = ~clock;

    fetch_pc_gen #(.RESET_VECTOR(c_RV)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_redirect_valid       (io_redirect_valid),
        .io_redirect_target      (io_redirect_target),
        .io_btb_req_pc           (io_btb_req_pc),
        .io_btb_hit              (io_btb_hit),
        .io_btb_target           (io_btb_target),
        .io_btb_jump             (io_btb_jump),
        .io_out_valid            (io_out_valid),
        .io_out_ready            (io_out_ready),
        .io_out_bits_pc          (io_out_bits_pc),
        .io_out_bits_pred_taken  (io_out_bits_pred_taken),
        .io_out_bits_pred_target (io_out_bits_pred_target)
`ifdef FETCH_PC_GEN_PERF_EN
        ,
        .io_perf_pred_taken_cnt  (io_perf_pred_taken_cnt),
        .io_perf_redirect_cnt    (io_perf_redirect_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the fetch request currently on offer. Once a request
    // has been shown and not taken, its prediction is pinned until accepted.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_pinned;
    bit          m_pin_taken;
    logic [31:0] m_pin_target;
    logic [31:0] m_cnt_taken;
    logic [31:0] m_cnt_redir;

    // Values observed in the most recent step, for directed literal checks.
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic        obs_taken;
    logic [31:0] obs_target;
    logic [31:0] obs_btb_pc;

    task automatic step(input bit rst, input bit rv, input logic [31:0] rt,
                        input bit hit, input bit jmp, input logic [31:0] tgt,
                        input bit rdy);
        bit          e_valid;
        bit          e_taken;
        logic [31:0] e_target;
        bit          accepted;
        reset              = rst;
        io_redirect_valid  = rv;
        io_redirect_target = rt;
        io_btb_hit         = hit;
        io_btb_jump        = jmp;
        io_btb_target      = tgt;
        io_out_ready       = rdy;
        #1;
        e_valid  = !m_boot && !rv;
        e_taken  = m_pinned ? m_pin_taken  : (hit && jmp);
        e_target = m_pinned ? m_pin_target : (tgt & 32'hFFFF_FFFC);

        obs_valid  = io_out_valid;
        obs_pc     = io_out_bits_pc;
        obs_taken  = io_out_bits_pred_taken;
        obs_target = io_out_bits_pred_target;
        obs_btb_pc = io_btb_req_pc;

        n_tests++;
        if (io_out_valid !== e_valid) begin
            n_fail++;
            $display("FAIL valid t=%0t got %b want %b", $time, io_out_valid, e_valid);
        end
        if (e_valid) begin
            n_tests++;
            if (io_out_bits_pc !== m_pc) begin
                n_fail++;
                $display("FAIL pc t=%0t got %h want %h", $time, io_out_bits_pc, m_pc);
            end
            n_tests++;
            if (io_out_bits_pred_taken !== e_taken) begin
                n_fail++;
                $display("FAIL pred_taken t=%0t got %b want %b", $time, io_out_bits_pred_taken, e_taken);
            end
            if (e_taken) begin
                n_tests++;
                if (io_out_bits_pred_target !== e_target) begin
                    n_fail++;
                    $display("FAIL pred_target t=%0t got %h want %h", $time, io_out_bits_pred_target, e_target);
                end
            end
        end
        if (!m_pinned) begin
            n_tests++;
            if (io_btb_req_pc !== m_pc) begin
                n_fail++;
                $display("FAIL btb_req_pc t=%0t got %h want %h", $time, io_btb_req_pc, m_pc);
            end
        end
`ifdef FETCH_PC_GEN_PERF_EN
        n_tests++;
        if (io_perf_pred_taken_cnt !== m_cnt_taken) begin
            n_fail++;
            $display("FAIL perf_taken t=%0t got %0d want %0d", $time, io_perf_pred_taken_cnt, m_cnt_taken);
        end
        n_tests++;
        if (io_perf_redirect_cnt !== m_cnt_redir) begin
            n_fail++;
            $display("FAIL perf_redirect t=%0t got %0d want %0d", $time, io_perf_redirect_cnt, m_cnt_redir);
        end
`endif

        accepted = e_valid && rdy;
        if (rst) begin
            m_boot      = 1'b1;
            m_pc        = c_RV;
            m_pinned    = 1'b0;
            m_cnt_taken = 32'd0;
            m_cnt_redir = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (rv) begin
            m_pc        = rt & 32'hFFFF_FFFC;
            m_pinned    = 1'b0;
            m_cnt_redir = m_cnt_redir + 32'd1;
        end else if (accepted) begin
            if (e_taken) m_cnt_taken = m_cnt_taken + 32'd1;
            m_pc     = e_taken ? e_target : m_pc + 32'd4;
            m_pinned = 1'b0;
        end else begin
            m_pinned     = 1'b1;
            m_pin_taken  = e_taken;
            m_pin_target = e_target;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        lit("reset_valid", {31'd0, obs_valid}, 32'd0);
        lit("reset_btb_pc", obs_btb_pc, c_RV);
    endtask

    task automatic test_sequential();
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t1_boot_valid", {31'd0, obs_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t1_pc0", obs_pc, 32'h8000_0000);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t1_pc1", obs_pc, 32'h8000_0004);
    endtask

    task automatic test_btb_hit();
        step(0, 0, 0, 1, 1, 32'h8000_0103, 1);
        lit("t2_pc", obs_pc, 32'h8000_0008);
        lit("t2_taken", {31'd0, obs_taken}, 32'd1);
        lit("t2_target", obs_target, 32'h8000_0100);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t2_next_pc", obs_pc, 32'h8000_0100);
    endtask

    task automatic test_stall_hold();
        step(0, 1, 32'h8000_0010, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 32'h8000_0200, 0);
        step(0, 0, 0, 0, 1, 32'h1234_5678, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        lit("t3_hold_pc", obs_pc, 32'h8000_0010);
        lit("t3_hold_taken", {31'd0, obs_taken}, 32'd1);
        lit("t3_hold_target", obs_target, 32'h8000_0200);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t3_next_pc", obs_pc, 32'h8000_0200);
    endtask

    task automatic test_redirect();
        step(0, 1, 32'h8000_1002, 1, 1, 32'h8000_4000, 1);
        lit("t4_valid", {31'd0, obs_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t4_pc", obs_pc, 32'h8000_1000);
    endtask

    task automatic test_wrap_and_reset();
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t5_pc_top", obs_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("t5_pc_wrap", obs_pc, 32'h0000_0000);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t5_rst_valid", {31'd0, obs_valid}, 32'd0);
        lit("t5_rst_pc", obs_btb_pc, c_RV);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t5_first_pc", obs_pc, c_RV);
    endtask

`ifdef FETCH_PC_GEN_PERF_EN
    task automatic test_perf();
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 32'h8000_0103, 1);
        step(0, 1, 32'h8000_1002, 1, 1, 32'h8000_4000, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t6_taken_cnt", io_perf_pred_taken_cnt, 32'd1);
        lit("t6_redirect_cnt", io_perf_redirect_cnt, 32'd1);
    endtask
`endif

    task automatic test_random();
        bit          rst;
        bit          rv;
        logic [31:0] rt;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            rv  = !rst && ($urandom_range(0, 19) == 0);
            rt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(rst, rv, rt, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 $urandom, ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        reset              = 1'b1;
        io_redirect_valid  = 1'b0;
        io_redirect_target = 32'd0;
        io_btb_hit         = 1'b0;
        io_btb_jump        = 1'b0;
        io_btb_target      = 32'd0;
        io_out_ready       = 1'b1;
        @(posedge clock);
        #1;
        m_boot       = 1'b1;
        m_pc         = c_RV;
        m_pinned     = 1'b0;
        m_pin_taken  = 1'b0;
        m_pin_target = 32'd0;
        m_cnt_taken  = 32'd0;
        m_cnt_redir  = 32'd0;

        test_reset();
        test_sequential();
        test_btb_hit();
        test_stall_hold();
        test_redirect();
        test_wrap_and_reset();
`ifdef FETCH_PC_GEN_PERF_EN
        test_perf();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
